// File: rtl/imm_ext_pkg.sv
// Shared encodings and helpers for the immediate-extension unit.
// Mode encodings match the decode field; H is the number of fill bits above the raw immediate.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_SIGN     = 2'd0,
    MODE_ZERO     = 2'd1,
    MODE_SIGN_SHL = 2'd2,
    MODE_PREFIX   = 2'd3
  } imm_mode_e;

  typedef enum logic {
    PFX_UNARMED = 1'b0,
    PFX_ARMED   = 1'b1
  } pfx_state_e;

  function automatic int calc_h(input int in_width, input int out_width);
    return out_width - in_width;
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extension datapath: picks fill bits (sign, zero or prefix)
// and applies the branch-offset shift in SIGN_SHL mode.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_WIDTH  = 13,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT_AMT = 1,
  localparam int H = calc_h(IN_WIDTH, OUT_WIDTH)
) (
  input  logic [IN_WIDTH-1:0]  in_imm,
  input  logic [1:0]           mode,
  input  logic                 armed,
  input  logic [H-1:0]         prefix,
  output logic [OUT_WIDTH-1:0] ext_imm
);

  logic [H-1:0]         fill;
  logic [OUT_WIDTH-1:0] base;

  always_comb begin
    fill = '0;
    if (armed) begin
      fill = prefix;
    end else if (mode != MODE_ZERO) begin
      fill = {H{in_imm[IN_WIDTH-1]}};
    end
    base = {fill, in_imm};
    // Bits pushed past OUT_WIDTH are dropped; no overflow indication.
    ext_imm = (mode == MODE_SIGN_SHL) ? (base << SHIFT_AMT) : base;
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Immediate-extension stage: single-entry valid/ready output register plus a
// prefix register that supplies the high bits of the next extended immediate.
//   state       | meaning
//   PFX_UNARMED | no prefix held; fill comes from sign/zero extension
//   PFX_ARMED   | prefix_q supplies the fill bits of the next mode 0-2 accept
module imm_extend_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_WIDTH  = 13,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT_AMT = 1,
  localparam int H = calc_h(IN_WIDTH, OUT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_imm,
  input  logic [1:0]           in_mode,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_imm,
  output logic                 prefix_armed,
  output logic                 prefix_orphan
);

  pfx_state_e           state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_imm_q, out_imm_d;
  logic [H-1:0]         prefix_q, prefix_d;
  logic [H-1:0]         prefix_src;
  logic                 orphan_q, orphan_d;
  logic                 accept, is_prefix;
  logic [OUT_WIDTH-1:0] ext_imm;

  assign in_ready      = !out_valid_q || out_ready;
  assign accept        = in_valid && in_ready && !flush;
  assign is_prefix     = (in_mode == MODE_PREFIX);
  assign out_valid     = out_valid_q;
  assign out_imm       = out_imm_q;
  assign prefix_orphan = orphan_q;

  // A narrow raw immediate cannot fill a wide prefix; pad it with zeros.
  if (H <= IN_WIDTH) begin : g_pfx_slice
    assign prefix_src = in_imm[H-1:0];
  end else begin : g_pfx_pad
    assign prefix_src = {{(H-IN_WIDTH){1'b0}}, in_imm};
  end

  imm_ext_core #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT_AMT(SHIFT_AMT)
  ) u_core (
    .in_imm (in_imm),
    .mode   (in_mode),
    .armed  (state_q == PFX_ARMED),
    .prefix (prefix_q),
    .ext_imm(ext_imm)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PFX_UNARMED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = PFX_UNARMED;
    end else if (accept) begin
      state_d = is_prefix ? PFX_ARMED : PFX_UNARMED;
    end
  end

  always_comb begin
    prefix_armed = (state_q == PFX_ARMED);
    orphan_d     = accept && is_prefix && (state_q == PFX_ARMED);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    prefix_d    = prefix_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept && !is_prefix) begin
      out_valid_d = 1'b1;
      out_imm_d   = ext_imm;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept && is_prefix) begin
      prefix_d = prefix_src;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      prefix_q    <= '0;
      orphan_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      prefix_q    <= prefix_d;
      orphan_q    <= orphan_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed bench for imm_extend_unit at default parameters (13 -> 16, shift 1).
module tb_imm_extend_unit;

  localparam logic [1:0] M_SIGN = 2'd0;
  localparam logic [1:0] M_ZERO = 2'd1;
  localparam logic [1:0] M_SHL  = 2'd2;
  localparam logic [1:0] M_PFX  = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_imm;
  logic [1:0]  in_mode;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic        prefix_armed;
  logic        prefix_orphan;

  int errors = 0;
  int checks = 0;

  imm_extend_unit #(
    .IN_WIDTH (13),
    .OUT_WIDTH(16),
    .SHIFT_AMT(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_imm       (in_imm),
    .in_mode      (in_mode),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_imm      (out_imm),
    .prefix_armed (prefix_armed),
    .prefix_orphan(prefix_orphan)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [12:0] imm);
    in_valid = v;
    in_mode  = m;
    in_imm   = imm;
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_imm !== 16'h0000) begin errors++; $display("FAIL reset_imm got %h exp 0000", out_imm); end
    checks++; if (prefix_armed !== 1'b0) begin errors++; $display("FAIL reset_armed got %b exp 0", prefix_armed); end
    checks++; if (prefix_orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan got %b exp 0", prefix_orphan); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_sign_zero;
    drive(1'b1, M_SIGN, 13'h1000); tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sign_neg_valid got %b exp 1", out_valid); end
    checks++; if (out_imm !== 16'hF000) begin errors++; $display("FAIL sign_neg got %h exp F000", out_imm); end
    drive(1'b1, M_ZERO, 13'h1FFF); tick;
    checks++; if (out_imm !== 16'h1FFF) begin errors++; $display("FAIL zero_ext got %h exp 1FFF", out_imm); end
    drive(1'b1, M_SIGN, 13'h0FFF); tick;
    checks++; if (out_imm !== 16'h0FFF) begin errors++; $display("FAIL sign_pos_max got %h exp 0FFF", out_imm); end
    drive(1'b0, M_SIGN, 13'h0000); tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sign_idle_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_sign_shl;
    drive(1'b1, M_SHL, 13'h1FFF); tick;
    checks++; if (out_imm !== 16'hFFFE) begin errors++; $display("FAIL shl_neg1 got %h exp FFFE", out_imm); end
    drive(1'b1, M_SHL, 13'h0005); tick;
    checks++; if (out_imm !== 16'h000A) begin errors++; $display("FAIL shl_5 got %h exp 000A", out_imm); end
    drive(1'b1, M_SHL, 13'h1000); tick;
    checks++; if (out_imm !== 16'hE000) begin errors++; $display("FAIL shl_minneg got %h exp E000", out_imm); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL shl_b2b_valid got %b exp 1", out_valid); end
    drive(1'b0, M_SIGN, 13'h0000); tick;
  endtask

  task automatic test_prefix;
    drive(1'b1, M_PFX, 13'h0005); tick;
    checks++; if (prefix_armed !== 1'b1) begin errors++; $display("FAIL pfx_armed got %b exp 1", prefix_armed); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pfx_no_output got %b exp 0", out_valid); end
    drive(1'b1, M_ZERO, 13'h0123); tick;
    checks++; if (out_imm !== 16'hA123) begin errors++; $display("FAIL pfx_zero got %h exp A123", out_imm); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pfx_zero_valid got %b exp 1", out_valid); end
    checks++; if (prefix_armed !== 1'b0) begin errors++; $display("FAIL pfx_consumed got %b exp 0", prefix_armed); end
    drive(1'b1, M_PFX, 13'h0001); tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pfx_handshake_clear got %b exp 0", out_valid); end
    drive(1'b1, M_SHL, 13'h0001); tick;
    checks++; if (out_imm !== 16'h4002) begin errors++; $display("FAIL pfx_shl got %h exp 4002", out_imm); end
    drive(1'b0, M_SIGN, 13'h0000); tick;
  endtask

  task automatic test_orphan;
    drive(1'b1, M_PFX, 13'h0001); tick;
    checks++; if (prefix_orphan !== 1'b0) begin errors++; $display("FAIL orphan_first got %b exp 0", prefix_orphan); end
    drive(1'b1, M_PFX, 13'h0007); tick;
    checks++; if (prefix_orphan !== 1'b1) begin errors++; $display("FAIL orphan_pulse got %b exp 1", prefix_orphan); end
    checks++; if (prefix_armed !== 1'b1) begin errors++; $display("FAIL orphan_armed got %b exp 1", prefix_armed); end
    drive(1'b1, M_SIGN, 13'h0000); tick;
    checks++; if (prefix_orphan !== 1'b0) begin errors++; $display("FAIL orphan_drop got %b exp 0", prefix_orphan); end
    checks++; if (out_imm !== 16'hE000) begin errors++; $display("FAIL orphan_new_pfx got %h exp E000", out_imm); end
    checks++; if (prefix_armed !== 1'b0) begin errors++; $display("FAIL orphan_consumed got %b exp 0", prefix_armed); end
    drive(1'b0, M_SIGN, 13'h0000); tick;
  endtask

  task automatic test_backpressure;
    drive(1'b1, M_ZERO, 13'h0042); tick;
    checks++; if (out_imm !== 16'h0042) begin errors++; $display("FAIL bp_first got %h exp 0042", out_imm); end
    out_ready = 1'b0;
    drive(1'b1, M_ZERO, 13'h0055);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
      tick;
      checks++; if (out_imm !== 16'h0042) begin errors++; $display("FAIL bp_hold[%0d] got %h exp 0042", i, out_imm); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    tick;
    checks++; if (out_imm !== 16'h0055) begin errors++; $display("FAIL bp_second got %h exp 0055", out_imm); end
    drive(1'b0, M_SIGN, 13'h0000); tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_flush;
    drive(1'b1, M_ZERO, 13'h0077); tick;
    out_ready = 1'b0;
    drive(1'b1, M_ZERO, 13'h0011);
    flush = 1'b1; tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stalled got %b exp 0", out_valid); end
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, M_PFX, 13'h0003); tick;
    checks++; if (prefix_armed !== 1'b1) begin errors++; $display("FAIL flush_arm got %b exp 1", prefix_armed); end
    drive(1'b1, M_SIGN, 13'h0111);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", in_ready); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %b exp 0", out_valid); end
    checks++; if (prefix_armed !== 1'b0) begin errors++; $display("FAIL flush_disarm got %b exp 0", prefix_armed); end
    flush = 1'b0;
    drive(1'b1, M_ZERO, 13'h0001); tick;
    checks++; if (out_imm !== 16'h0001) begin errors++; $display("FAIL flush_no_pfx got %h exp 0001", out_imm); end
    drive(1'b0, M_SIGN, 13'h0000); tick;
  endtask

  task automatic test_async_reset;
    drive(1'b1, M_PFX, 13'h0001); tick;
    drive(1'b1, M_PFX, 13'h0002); tick;
    drive(1'b0, M_SIGN, 13'h0000);
    #2 reset = 1'b1;
    #1;
    checks++; if (prefix_armed !== 1'b0) begin errors++; $display("FAIL areset_armed got %b exp 0", prefix_armed); end
    checks++; if (prefix_orphan !== 1'b0) begin errors++; $display("FAIL areset_orphan got %b exp 0", prefix_orphan); end
    checks++; if (out_imm !== 16'h0000) begin errors++; $display("FAIL areset_imm1 got %h exp 0000", out_imm); end
    reset = 1'b0;
    drive(1'b1, M_ZERO, 13'h0099); tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %b exp 1", out_valid); end
    out_ready = 1'b0;
    drive(1'b0, M_SIGN, 13'h0000);
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", out_valid); end
    checks++; if (out_imm !== 16'h0000) begin errors++; $display("FAIL areset_imm2 got %h exp 0000", out_imm); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b exp 1", in_ready); end
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, M_SIGN, 13'h1234); tick;
    checks++; if (out_imm !== 16'hF234) begin errors++; $display("FAIL areset_resume got %h exp F234", out_imm); end
    drive(1'b0, M_SIGN, 13'h0000); tick;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = M_SIGN;
    flush     = 1'b0;
    out_ready = 1'b1;
    test_reset;
    test_sign_zero;
    test_sign_shl;
    test_prefix;
    test_orphan;
    test_backpressure;
    test_flush;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
